// File: rtl/instr_mem_sync_pkg.sv
// ============================================================================
// Module   : instr_mem_sync_pkg
// Brief    : Shared widths, NOP fill encoding and FSM state type for the
//            writable synchronous instruction memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

package instr_mem_sync_pkg;

  localparam int          ADDR_W_DEF = 4;
  localparam int          DATA_W_DEF = 32;
  // ARM "MOV R0,R0", used as the architectural NOP
  localparam logic [31:0] NOP_WORD   = 32'hE1A00000;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage : instr_mem_sync_pkg

`default_nettype wire

// File: rtl/instr_mem_sync_mem_array.sv
// ============================================================================
// Module   : mem_array_1w1r
// Brief    : DEPTH x DATA_W storage, one write port, one registered read
//            port with write-first bypass on an address collision.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_array_1w1r #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              collide;

  assign collide = we && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata only moves when a read is issued, so it doubles as the hold register
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= collide ? wdata : mem[raddr];
    end
  end

endmodule : mem_array_1w1r

`default_nettype wire

// File: rtl/instr_mem_sync.sv
// ============================================================================
// Module   : instr_mem_sync
// Brief    : Writable instruction memory: power-up NOP fill, program-load
//            port and 1-cycle fetch port with stall/flush control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_mem_sync
  import instr_mem_sync_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter int          DATA_W    = DATA_W_DEF,
  parameter logic [31:0] FILL_WORD = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] PC_out,
  input  logic              fetch_req,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] IR_out,
  output logic              ir_valid,
  output logic              ready
);

  localparam logic [DATA_W-1:0] FILL_D    = DATA_W'(FILL_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              fill_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // When set, IR_out presents the NOP instead of the last read word
  logic              show_fill;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  assign fill_last = (cnt == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (fill_last) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign ready = (state == ST_READY);

  // ------------------------------------------------------- fill counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ------------------------------------------------ write / read ports
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    mem_re    = 1'b0;
    if (rst_n) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = FILL_D;
      end else begin
        mem_we = load_en;
        mem_re = fetch_req && !stall && !flush;
      end
    end
  end

  mem_array_1w1r #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (PC_out),
    .rdata (mem_rdata)
  );

  // ------------------------------------------- output register priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_valid  <= 1'b0;
      show_fill <= 1'b1;
    end else if (state == ST_READY) begin
      if (flush) begin
        ir_valid  <= 1'b0;
        show_fill <= 1'b1;
      end else if (stall) begin
        ir_valid  <= ir_valid;
        show_fill <= show_fill;
      end else if (fetch_req) begin
        ir_valid  <= 1'b1;
        show_fill <= 1'b0;
      end else begin
        ir_valid  <= 1'b0;
      end
    end
  end

  assign IR_out = show_fill ? FILL_D : mem_rdata;

endmodule : instr_mem_sync

`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
// ============================================================================
// Module   : tb_instr_mem_sync
// Brief    : Directed vector bench for instr_mem_sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  PC_out;
  logic        fetch_req;
  logic        stall;
  logic        flush;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] IR_out;
  logic        ir_valid;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        fetch_req;
    logic [3:0]  pc;
    logic        stall;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_ir;
  } vec_t;

  vec_t vecs [22];

  always #5 clk = ~clk;

  instr_mem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PC_out    (PC_out),
    .fetch_req (fetch_req),
    .stall     (stall),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .IR_out    (IR_out),
    .ir_valid  (ir_valid),
    .ready     (ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; PC_out = '0;
  endtask

  // Waits out the fill after rst_n rises: ready must read 0 for 16 samples, then 1.
  task automatic check_fill(input string tag);
    check({tag, "_ready_lo0"}, {31'd0, ready}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      check({tag, "_ready_lo"}, {31'd0, ready}, 32'd0);
      check({tag, "_valid_lo"}, {31'd0, ir_valid}, 32'd0);
    end
    step();
    check({tag, "_ready_hi"}, {31'd0, ready}, 32'd1);
    check({tag, "_valid_after_fill"}, {31'd0, ir_valid}, 32'd0);
  endtask

  task automatic fetch_one(input logic [3:0] a, input logic [31:0] exp, input string name);
    idle_inputs();
    fetch_req = 1'b1; PC_out = a;
    step();
    check({name, "_ir"}, IR_out, exp);
    check({name, "_valid"}, {31'd0, ir_valid}, 32'd1);
  endtask

  initial begin
    //          ld  la     ldata         fr  pc     st  fl  ev  exp_ir
    vecs[0]  = '{1, 4'd0,  32'hE3A11016, 0, 4'd0,  0, 0, 0, NOP};
    vecs[1]  = '{1, 4'd1,  32'hE3A22005, 0, 4'd0,  0, 0, 0, NOP};
    vecs[2]  = '{1, 4'd2,  32'hE3A33003, 0, 4'd0,  0, 0, 0, NOP};
    vecs[3]  = '{0, 4'd0,  32'h0,        1, 4'd0,  0, 0, 1, 32'hE3A11016};
    vecs[4]  = '{0, 4'd0,  32'h0,        1, 4'd1,  0, 0, 1, 32'hE3A22005};
    vecs[5]  = '{0, 4'd0,  32'h0,        1, 4'd2,  0, 0, 1, 32'hE3A33003};
    vecs[6]  = '{0, 4'd0,  32'h0,        1, 4'd1,  0, 0, 1, 32'hE3A22005};
    vecs[7]  = '{0, 4'd0,  32'h0,        1, 4'd3,  1, 0, 1, 32'hE3A22005};
    vecs[8]  = '{0, 4'd0,  32'h0,        1, 4'd0,  1, 0, 1, 32'hE3A22005};
    vecs[9]  = '{0, 4'd0,  32'h0,        1, 4'd2,  1, 0, 1, 32'hE3A22005};
    vecs[10] = '{0, 4'd0,  32'h0,        1, 4'd2,  1, 1, 0, NOP};
    vecs[11] = '{0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 0, NOP};
    vecs[12] = '{1, 4'd5,  32'h06010012, 1, 4'd5,  0, 0, 1, 32'h06010012};
    vecs[13] = '{0, 4'd0,  32'h0,        1, 4'd5,  0, 0, 1, 32'h06010012};
    vecs[14] = '{1, 4'd3,  32'hE0810312, 1, 4'd6,  0, 0, 1, NOP};
    vecs[15] = '{0, 4'd0,  32'h0,        1, 4'd3,  0, 0, 1, 32'hE0810312};
    vecs[16] = '{1, 4'd4,  32'h12345678, 1, 4'd4,  1, 0, 1, 32'hE0810312};
    vecs[17] = '{1, 4'd8,  32'hCAFEF00D, 1, 4'd8,  0, 1, 0, NOP};
    vecs[18] = '{0, 4'd0,  32'h0,        1, 4'd4,  0, 0, 1, 32'h12345678};
    vecs[19] = '{0, 4'd0,  32'h0,        1, 4'd8,  0, 0, 1, 32'hCAFEF00D};
    vecs[20] = '{0, 4'd0,  32'h0,        1, 4'd15, 0, 0, 1, NOP};
    vecs[21] = '{0, 4'd0,  32'h0,        0, 4'd0,  0, 0, 0, NOP};

    // Reset, with stray fetch/load requests held through the fill
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_ir", IR_out, NOP);
    rst_n = 1'b1;
    fetch_req = 1'b1; PC_out = 4'd7;
    load_en = 1'b1; load_addr = 4'd7; load_data = 32'h8A000008;
    check_fill("fill1");
    check("fill1_ir", IR_out, NOP);

    // Every word reads back as the NOP, including the one loaded during INIT
    for (int a = 0; a < 16; a++) begin
      fetch_one(4'(a), NOP, $sformatf("fill_rd%0d", a));
    end

    // Table-driven vectors: load/fetch, stall/flush, collisions
    for (int i = 0; i < 22; i++) begin
      load_en   = vecs[i].load_en;
      load_addr = vecs[i].load_addr;
      load_data = vecs[i].load_data;
      fetch_req = vecs[i].fetch_req;
      PC_out    = vecs[i].pc;
      stall     = vecs[i].stall;
      flush     = vecs[i].flush;
      step();
      check($sformatf("vec%0d_ir", i), IR_out, vecs[i].exp_ir);
      check($sformatf("vec%0d_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_ready", i), {31'd0, ready}, 32'd1);
    end

    // Reset mid-run wipes loaded words and reruns the fill
    fetch_one(4'd3, 32'hE0810312, "pre_rst");
    fetch_req = 1'b1;
    rst_n = 1'b0;
    step();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
    check("mid_rst_ir", IR_out, NOP);
    rst_n = 1'b1;
    idle_inputs();
    check_fill("fill2");
    fetch_one(4'd3, NOP, "post_rst_a3");
    fetch_one(4'd4, NOP, "post_rst_a4");
    fetch_one(4'd7, NOP, "post_rst_a7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instr_mem_sync

`default_nettype wire
